// File: rtl/snake_pkg.sv
// Shared definitions for the snake screen controller: phase encoding,
// default background colour and the RGB565 dimming helper.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  localparam logic [15:0] COLOR_BACK_DFLT = 16'h0000;

  // Halve each RGB565 field independently; the freed MSB of every field is zero.
  function automatic logic [15:0] dim565(input logic [15:0] c);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = c[15:11];
    g = c[10:5];
    b = c[4:0];
    return {r >> 1, g >> 1, b >> 1};
  endfunction

endpackage

// File: rtl/snake_frame_timer.sv
// Frame-counted timers for the FAIL screen: a saturating hold counter that
// gates restart keys, and a wrapping blink counter that toggles the overlay.
module snake_frame_timer #(
  parameter int BLINK_FRAMES     = 30,
  parameter int FAIL_HOLD_FRAMES = 60
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic frame_start,
  output logic hold_done,
  output logic blink_on
);

  localparam int HW = $clog2(FAIL_HOLD_FRAMES + 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_MAX   = HW'(FAIL_HOLD_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blink_cnt;

  assign hold_done = (hold_cnt == HOLD_MAX);

  // Count frames; clear wins so the entry frame itself is not counted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_cnt  <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (clear) begin
      hold_cnt  <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (!hold_done) hold_cnt <= hold_cnt + 1'b1;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_screen_ctrl.sv
// Game-screen controller: IDLE/PLAY/FAIL sequencing on frame boundaries,
// game gating/restart, and compositing of game layer with the fail overlay.
module snake_screen_ctrl
  import snake_pkg::*;
#(
  parameter int          H_ACTIVE         = 640,
  parameter int          V_ACTIVE         = 480,
  parameter int          BLINK_FRAMES     = 30,
  parameter int          FAIL_HOLD_FRAMES = 60,
  parameter logic [15:0] COLOR_BACK       = COLOR_BACK_DFLT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        frame_start,
  input  logic        key_start,
  input  logic        snake_dead,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic [15:0] pixel_game,
  input  logic [15:0] pixel_fail,
  output logic [15:0] pixel_data,
  output logic        game_en,
  output logic        game_rst,
  output logic [1:0]  state
);

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

  state_t st;
  logic   key_q;
  logic   key_edge;
  logic   start_req;
  logic   dead_req;
  logic   start_now;
  logic   dead_now;
  logic   fail_entry;
  logic   hold_done;
  logic   blink_on;
  logic   act_p1;

  assign key_edge   = key_start & ~key_q;
  // Requests raised in a frame_start cycle take effect on that same edge.
  assign start_now  = start_req |
                      (key_edge & ((st == ST_IDLE) | ((st == ST_FAIL) & hold_done)));
  assign dead_now   = dead_req | (snake_dead & (st == ST_PLAY));
  assign fail_entry = (st == ST_PLAY) & frame_start & dead_now;
  assign game_en    = (st == ST_PLAY);
  assign state      = st;

  snake_frame_timer #(
    .BLINK_FRAMES     (BLINK_FRAMES),
    .FAIL_HOLD_FRAMES (FAIL_HOLD_FRAMES)
  ) u_timer (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (fail_entry),
    .frame_start (frame_start),
    .hold_done   (hold_done),
    .blink_on    (blink_on)
  );

  // Previous key level for rising-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) key_q <= 1'b0;
    else       key_q <= key_start;
  end

  // Phase FSM with pending request flags; phase changes only on frame_start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st        <= ST_IDLE;
      game_rst  <= 1'b0;
      start_req <= 1'b0;
      dead_req  <= 1'b0;
    end else begin
      game_rst <= 1'b0;
      case (st)
        ST_IDLE, ST_FAIL: begin
          if (frame_start && start_now) begin
            st        <= ST_PLAY;
            game_rst  <= 1'b1;
            start_req <= 1'b0;
          end else begin
            start_req <= start_now;
          end
        end
        ST_PLAY: begin
          if (frame_start && dead_now) begin
            st       <= ST_FAIL;
            dead_req <= 1'b0;
          end else begin
            dead_req <= dead_now;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: active-area flag aligned with the registered layer inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) act_p1 <= 1'b0;
    else       act_p1 <= (pixel_xpos < H_LIM) && (pixel_ypos < V_LIM);
  end

  // Stage p1 -> output: composite game layer and blinking overlay.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pixel_data <= COLOR_BACK;
    end else if (!act_p1) begin
      pixel_data <= COLOR_BACK;
    end else if (st == ST_FAIL) begin
      if (blink_on && (pixel_fail != COLOR_BACK)) pixel_data <= pixel_fail;
      else                                         pixel_data <= dim565(pixel_game);
    end else begin
      pixel_data <= pixel_game;
    end
  end

endmodule

// File: tb/tb_snake_screen_ctrl.sv
// Directed self-checking bench for snake_screen_ctrl with default parameters.
module tb_snake_screen_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        frame_start = 1'b0;
  logic        key_start = 1'b0;
  logic        snake_dead = 1'b0;
  logic [10:0] pixel_xpos = 11'd0;
  logic [10:0] pixel_ypos = 11'd0;
  logic [15:0] pixel_game = 16'h0000;
  logic [15:0] pixel_fail = 16'h0000;
  logic [15:0] pixel_data;
  logic        game_en;
  logic        game_rst;
  logic [1:0]  state;

  int n_chk = 0;
  int n_fail = 0;

  snake_screen_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .frame_start (frame_start),
    .key_start   (key_start),
    .snake_dead  (snake_dead),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .pixel_game  (pixel_game),
    .pixel_fail  (pixel_fail),
    .pixel_data  (pixel_data),
    .game_en     (game_en),
    .game_rst    (game_rst),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic key_edge_pulse;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) tick();
    n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
    n_chk++; if (game_en !== 1'b0) begin n_fail++; $display("FAIL reset_game_en got %b exp 0", game_en); end
    n_chk++; if (game_rst !== 1'b0) begin n_fail++; $display("FAIL reset_game_rst got %b exp 0", game_rst); end
    n_chk++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL reset_pixel got %h exp 0000", pixel_data); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_start_deferred;
    pixel_xpos = 11'd100; pixel_ypos = 11'd10; pixel_game = 16'h1234;
    key_start = 1'b1;
    tick();
    tick();
    n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL start_wait_state got %0d exp 0", state); end
    n_chk++; if (pixel_data !== 16'h1234) begin n_fail++; $display("FAIL idle_pixel got %h exp 1234", pixel_data); end
    frame_start = 1'b1;
    tick();
    n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_state got %0d exp 1", state); end
    n_chk++; if (game_rst !== 1'b1) begin n_fail++; $display("FAIL start_game_rst got %b exp 1", game_rst); end
    n_chk++; if (game_en !== 1'b1) begin n_fail++; $display("FAIL start_game_en got %b exp 1", game_en); end
    frame_start = 1'b0;
    tick();
    n_chk++; if (game_rst !== 1'b0) begin n_fail++; $display("FAIL start_game_rst_len got %b exp 0", game_rst); end
    key_start = 1'b0;
    tick();
  endtask

  task automatic test_offscreen;
    pixel_xpos = 11'd100; pixel_ypos = 11'd10; pixel_game = 16'h1234;
    tick(); tick();
    n_chk++; if (pixel_data !== 16'h1234) begin n_fail++; $display("FAIL play_pixel got %h exp 1234", pixel_data); end
    pixel_xpos = 11'd700;
    tick();
    n_chk++; if (pixel_data !== 16'h1234) begin n_fail++; $display("FAIL x_latency got %h exp 1234", pixel_data); end
    tick();
    n_chk++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL x_offscreen got %h exp 0000", pixel_data); end
    pixel_xpos = 11'd639; pixel_ypos = 11'd480;
    tick(); tick();
    n_chk++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL y_offscreen got %h exp 0000", pixel_data); end
    pixel_ypos = 11'd479;
    tick(); tick();
    n_chk++; if (pixel_data !== 16'h1234) begin n_fail++; $display("FAIL corner_pixel got %h exp 1234", pixel_data); end
    pixel_xpos = 11'd100; pixel_ypos = 11'd10;
  endtask

  task automatic test_dead_and_key;
    key_start = 1'b1; snake_dead = 1'b1;
    tick();
    key_start = 1'b0; snake_dead = 1'b0;
    tick();
    n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL dead_wait_state got %0d exp 1", state); end
    frame_start = 1'b1;
    tick();
    n_chk++; if (state !== 2'd2) begin n_fail++; $display("FAIL dead_state got %0d exp 2", state); end
    n_chk++; if (game_en !== 1'b0) begin n_fail++; $display("FAIL dead_game_en got %b exp 0", game_en); end
    n_chk++; if (game_rst !== 1'b0) begin n_fail++; $display("FAIL dead_game_rst got %b exp 0", game_rst); end
    frame_start = 1'b0;
    tick();
    n_chk++; if (state !== 2'd2) begin n_fail++; $display("FAIL dead_hold_state got %0d exp 2", state); end
  endtask

  task automatic test_fail_overlay;
    pixel_fail = 16'hF00F; pixel_game = 16'hFFFF;
    tick(); tick();
    n_chk++; if (pixel_data !== 16'hF00F) begin n_fail++; $display("FAIL overlay_on got %h exp f00f", pixel_data); end
    pixel_fail = 16'h0000;
    tick(); tick();
    n_chk++; if (pixel_data !== 16'h7BEF) begin n_fail++; $display("FAIL overlay_dim got %h exp 7bef", pixel_data); end
    pixel_fail = 16'hF00F;
    tick(); tick();
  endtask

  task automatic test_hold_and_blink;
    repeat (10) pulse_frame();
    key_edge_pulse();
    pulse_frame();
    n_chk++; if (state !== 2'd2) begin n_fail++; $display("FAIL early_key_state got %0d exp 2", state); end
    repeat (18) pulse_frame();
    n_chk++; if (pixel_data !== 16'hF00F) begin n_fail++; $display("FAIL blink_f29 got %h exp f00f", pixel_data); end
    pulse_frame();
    n_chk++; if (pixel_data !== 16'h7BEF) begin n_fail++; $display("FAIL blink_f30 got %h exp 7bef", pixel_data); end
    repeat (30) pulse_frame();
    n_chk++; if (pixel_data !== 16'hF00F) begin n_fail++; $display("FAIL blink_f60 got %h exp f00f", pixel_data); end
    pulse_frame();
    n_chk++; if (state !== 2'd2) begin n_fail++; $display("FAIL no_latch_state got %0d exp 2", state); end
    key_edge_pulse();
    n_chk++; if (state !== 2'd2) begin n_fail++; $display("FAIL restart_wait_state got %0d exp 2", state); end
    frame_start = 1'b1;
    tick();
    n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL restart_state got %0d exp 1", state); end
    n_chk++; if (game_rst !== 1'b1) begin n_fail++; $display("FAIL restart_game_rst got %b exp 1", game_rst); end
    frame_start = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_fail;
    snake_dead = 1'b1;
    tick();
    snake_dead = 1'b0;
    pulse_frame();
    n_chk++; if (state !== 2'd2) begin n_fail++; $display("FAIL refail_state got %0d exp 2", state); end
    repeat (30) pulse_frame();
    n_chk++; if (pixel_data !== 16'h7BEF) begin n_fail++; $display("FAIL refail_blink_off got %h exp 7bef", pixel_data); end
    #2;
    rstn = 1'b0;
    #1;
    n_chk++; if (pixel_data !== 16'h0000) begin n_fail++; $display("FAIL async_rst_pixel got %h exp 0000", pixel_data); end
    n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL async_rst_state got %0d exp 0", state); end
    n_chk++; if (game_en !== 1'b0) begin n_fail++; $display("FAIL async_rst_game_en got %b exp 0", game_en); end
    tick();
    rstn = 1'b1;
    tick();
    repeat (3) pulse_frame();
    n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL post_rst_state got %0d exp 0", state); end
    n_chk++; if (game_rst !== 1'b0) begin n_fail++; $display("FAIL post_rst_game_rst got %b exp 0", game_rst); end
    key_edge_pulse();
    frame_start = 1'b1;
    tick();
    n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL post_rst_start got %0d exp 1", state); end
    frame_start = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_start_deferred();
    test_offscreen();
    test_dead_and_key();
    test_fail_overlay();
    test_hold_and_blink();
    test_reset_in_fail();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_screen_ctrl.md
# snake_screen_ctrl

Game-screen controller for the snake VGA pipeline. It sequences the game through idle, play and fail phases, gates and restarts the game logic, and composites the game layer with the 16-bit RGB565 fail/restart text overlay into the single pixel stream sent to the VGA driver. All phase changes are deferred to a frame boundary so a frame is never torn between screens.

## Interface
Parameters:
- H_ACTIVE, 640: active width in pixels.
- V_ACTIVE, 480: active height in lines.
- BLINK_FRAMES, 30: frames per overlay blink half-period. Must be at least 1.
- FAIL_HOLD_FRAMES, 60: minimum frames in FAIL before a restart key is accepted. Must be at least 1.
- COLOR_BACK, 16'h0000: background and blanking colour.

Ports:
- clk, input, 1: VGA pixel clock.
- rstn, input, 1: asynchronous active-low reset.
- frame_start, input, 1: one-cycle pulse at the start of vertical blank.
- key_start, input, 1: debounced, synchronous start/restart key level.
- snake_dead, input, 1: one-cycle pulse from the game logic on collision.
- pixel_xpos, input, 11: current pixel x.
- pixel_ypos, input, 11: current pixel y.
- pixel_game, input, 16: game layer colour, registered one cycle after xpos/ypos.
- pixel_fail, input, 16: text overlay colour, registered one cycle after xpos/ypos.
- pixel_data, output, 16: composited colour to the VGA driver.
- game_en, output, 1: game logic advance enable.
- game_rst, output, 1: one-cycle synchronous restart pulse to the game logic.
- state, output, 2: current phase: 0 IDLE, 1 PLAY, 2 FAIL.

## Operation
- Key edge detection: key_edge = key_start & ~key_start_q. key_start_q resets to 0.
- Pending flags:
  - start_req is set by key_edge in IDLE, or by key_edge in FAIL once hold_done=1.
  - dead_req is set by snake_dead in PLAY.
  - Both flags clear on the transition they cause.
- Transitions happen only in a cycle with frame_start=1. A request raised in that same cycle counts.
- FSM:
  - IDLE: start_req & frame_start goes to PLAY and pulses game_rst.
  - PLAY: dead_req & frame_start goes to FAIL.
  - FAIL: start_req & frame_start goes to PLAY and pulses game_rst.
  - There is no other transition.
- PLAY precedence: if snake_dead and key_edge occur in the same cycle, dead wins and the key is ignored.
- game_en = (state==PLAY). It drops in the same cycle the state leaves PLAY.
- FAIL counters (sub-module, all count frame_start pulses):
  - hold_cnt saturates at FAIL_HOLD_FRAMES. hold_done = (hold_cnt==FAIL_HOLD_FRAMES).
  - Key edges before hold_done are discarded, not latched.
  - blink_cnt counts 0..BLINK_FRAMES-1 and then wraps. Each wrap toggles blink_on.
  - blink_on=1 on entry to FAIL.
  - All counters clear on entry to FAIL.
- Compositing, using x and y delayed one cycle to align with the layer inputs:
  - Outside the active area (x≥H_ACTIVE or y≥V_ACTIVE): COLOR_BACK.
  - IDLE and PLAY: pixel_game.
  - FAIL: if blink_on & pixel_fail≠COLOR_BACK, output pixel_fail. Otherwise output dim(pixel_game) = {r[4:1]→5b, g[5:1]→6b, b[4:1]→5b}, i.e. each RGB565 field shifted right by 1 with a zero MSB.
- Reset: state=IDLE, game_en=0, game_rst=0, pixel_data=COLOR_BACK, all flags and counters 0.
- Reset asserted mid-frame or mid-FAIL aborts immediately. There is no pending restart after reset release.

## Timing
- pixel_data is registered. It appears 1 cycle after pixel_game/pixel_fail and 2 cycles after the matching pixel_xpos/ypos.
- state updates on the clock edge at which frame_start=1. game_rst is high for exactly that following cycle.
- game_en follows state combinationally from the registered state.
- frame_start pulses closer together than 2 cycles are not supported.

## Structure
- Shared package snake_pkg holds:
  - the state encoding (IDLE=0, PLAY=1, FAIL=2);
  - the COLOR_BACK default;
  - an RGB565 dim function.
- Sub-module snake_frame_timer owns the frame-counted hold and blink counters.
  - Inputs: clear, frame_start.
  - Outputs: hold_done, blink_on.
- The FSM, edge detection and compositing mux stay in the top level.

## Test plan
- Reset, then key_start rising mid-frame → state stays 0 until the next frame_start. At that edge state=1, game_rst is high 1 cycle, game_en=1.
- In PLAY, snake_dead and key_edge in the same cycle → next frame_start gives state=2, game_en=0, no game_rst.
- In FAIL with default parameters, a key edge at frame 10 is ignored and state stays 2. A key edge at frame 61 restarts on the following frame_start.
- In FAIL, pixel_fail=16'hF00F and pixel_game=16'hFFFF → pixel_data=16'hF00F while blink_on=1. With pixel_fail=16'h0000 → pixel_data=16'h7BEF. blink_on toggles every 30 frames.
- pixel_xpos=700 in PLAY with pixel_game=16'h1234 → pixel_data=16'h0000 two cycles later.
- rstn low during FAIL blink-off → pixel_data=16'h0000, state=0, game_en=0 immediately. After release, no transition until a new key edge.
